fsmc_master: RTL and testbench

FPGA-side initiator for the multiplexed-address/data FSMC bus. It drives AD/NADV/NWE/NOE the way an STM32 FSMC (mode: multiplexed, NOR/PSRAM) does toward `fsmc_interface`. It turns a single-command valid/ready request into one complete bus cycle and returns a one-cycle response. It is used for FPGA-to-FPGA links and as a bus-functional master in loopback benches against `fsmc_interface`.

---
 rtl/fsmc_pkg.sv | 26 ++
 rtl/fsmc_phase_timer.sv | 26 ++
 rtl/fsmc_master.sv | 128 ++++++++++++
 tb/tb_fsmc_master.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// fsmc_pkg: shared widths, default bus timing and master FSM state type for
// the multiplexed-address/data FSMC initiator.
package fsmc_pkg;

  localparam int FSMC_AD_W   = 18;
  localparam int FSMC_DATA_W = 16;

  // Default phase lengths in clk cycles
  localparam int FSMC_DEF_ADDSET  = 2;
  localparam int FSMC_DEF_ADDHLD  = 1;
  localparam int FSMC_DEF_DATAST  = 4;
  localparam int FSMC_DEF_BUSTURN = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AHOLD,
    ST_DATA,
    ST_TURN
  } fsmc_mst_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// fsmc_phase_timer: loadable down-counter shared by all timed bus phases.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (phase entry, value is N-1)
//   load_val   : initial count
//   done       : count has reached zero (last cycle of the phase)
module fsmc_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/fsmc_master.sv
// fsmc_master: FSMC multiplexed-bus initiator (NOR/PSRAM muxed mode).
// Turns one accepted command into a full ADDR/AHOLD/DATA(/TURN) bus cycle
// and returns a one-cycle response.
//   clk, reset           : clock, synchronous active-high reset
//   AD                   : muxed address/data, released when not driven
//   NADV, NWE, NOE       : active-low address-valid / write / read strobes
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_write/addr/wdata : command fields, latched on accept
//   rsp_valid/rsp_rdata  : completion pulse, read data (0 for writes)
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDSET  = FSMC_DEF_ADDSET,
  parameter int ADDHLD  = FSMC_DEF_ADDHLD,
  parameter int DATAST  = FSMC_DEF_DATAST,
  parameter int BUSTURN = FSMC_DEF_BUSTURN
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [FSMC_AD_W-1:0]   AD,
  output logic                   NADV,
  output logic                   NWE,
  output logic                   NOE,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [FSMC_AD_W-1:0]   cmd_addr,
  input  logic [FSMC_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [FSMC_DATA_W-1:0] rsp_rdata
);

  localparam int MAX_P = max_int(max_int(ADDSET, ADDHLD), max_int(DATAST, BUSTURN));
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LD_ADDSET = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] LD_ADDHLD = CNT_W'(ADDHLD - 1);
  localparam logic [CNT_W-1:0] LD_DATAST = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] LD_TURN   = (BUSTURN > 0) ? CNT_W'(BUSTURN - 1) : '0;

  fsmc_mst_state_t state, state_n;

  logic                   tmr_load, tmr_done;
  logic [CNT_W-1:0]       tmr_val;
  logic                   accept, data_end;
  logic                   wr_q;
  logic [FSMC_DATA_W-1:0] wdata_q;
  logic [FSMC_AD_W-1:0]   ad_out;
  logic                   ad_oe;

  fsmc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Ready is a decode of the state register, gated so nothing is accepted
  // while reset is asserted and accepting resumes right after release.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign data_end  = (state == ST_DATA) && tmr_done;

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE:  if (accept) begin
                  state_n = ST_ADDR;  tmr_load = 1'b1; tmr_val = LD_ADDSET;
                end
      ST_ADDR:  if (tmr_done) begin
                  state_n = ST_AHOLD; tmr_load = 1'b1; tmr_val = LD_ADDHLD;
                end
      ST_AHOLD: if (tmr_done) begin
                  state_n = ST_DATA;  tmr_load = 1'b1; tmr_val = LD_DATAST;
                end
      ST_DATA:  if (tmr_done) begin
                  if (BUSTURN > 0) begin
                    state_n = ST_TURN; tmr_load = 1'b1; tmr_val = LD_TURN;
                  end else begin
                    state_n = ST_IDLE;
                  end
                end
      ST_TURN:  if (tmr_done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each pin is glitch-free
  // and lines up exactly with the state it belongs to. Direction (wr_q) is
  // stable long before DATA, so it is safe to use here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      NADV      <= 1'b1;
      NWE       <= 1'b1;
      NOE       <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      NADV  <= (state_n != ST_ADDR);
      NWE   <= !((state_n == ST_DATA) && wr_q);
      NOE   <= !((state_n == ST_DATA) && !wr_q);
      ad_oe <= (state_n == ST_ADDR) || (state_n == ST_AHOLD) ||
               ((state_n == ST_DATA) && wr_q);
      if (accept) begin
        wr_q    <= cmd_write;
        wdata_q <= cmd_wdata;
        ad_out  <= cmd_addr;
      end else if (state_n == ST_DATA) begin
        ad_out  <= {{(FSMC_AD_W-FSMC_DATA_W){1'b0}}, wdata_q};
      end
      rsp_valid <= data_end;
      // AD is released during read DATA, so the slave owns it at this edge.
      if (data_end) rsp_rdata <= wr_q ? '0 : AD[FSMC_DATA_W-1:0];
    end
  end

  assign AD = ad_oe ? ad_out : 'z;

endmodule

// File: tb/tb_fsmc_master.sv
module tb_fsmc_master;
  import fsmc_pkg::*;

  localparam int A = 2, H = 1, D = 4, B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          n_assert = 0;
  int          n_fail   = 0;

  // ---- default-timing DUT with a small memory-backed slave ----
  wire  [17:0] ad_bus;
  logic        nadv, nwe, noe, cmd_valid, cmd_ready, cmd_write, rsp_valid;
  logic [17:0] cmd_addr;
  logic [15:0] cmd_wdata, rsp_rdata;

  fsmc_master #(.ADDSET(A), .ADDHLD(H), .DATAST(D), .BUSTURN(B)) u_dut (
    .clk(clk), .reset(reset), .AD(ad_bus), .NADV(nadv), .NWE(nwe), .NOE(noe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata)
  );

  logic [17:0] slave_addr;
  logic [15:0] slave_mem [16];
  assign ad_bus = (noe == 1'b0) ? {2'b00, slave_mem[slave_addr[3:0]]} : 'z;
  always @(negedge clk) begin
    if (nadv == 1'b0) slave_addr <= ad_bus;
    if (nwe == 1'b0)  slave_mem[slave_addr[3:0]] <= ad_bus[15:0];
  end

  // ---- minimum-timing DUT with a fixed-value slave ----
  wire  [17:0] f_ad;
  logic        f_nadv, f_nwe, f_noe, f_cmd_valid, f_cmd_ready, f_cmd_write, f_rsp_valid;
  logic [17:0] f_cmd_addr;
  logic [15:0] f_cmd_wdata, f_rsp_rdata, f_drv;

  fsmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(0)) u_fast (
    .clk(clk), .reset(reset), .AD(f_ad), .NADV(f_nadv), .NWE(f_nwe), .NOE(f_noe),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_write(f_cmd_write),
    .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata), .rsp_valid(f_rsp_valid),
    .rsp_rdata(f_rsp_rdata)
  );
  assign f_ad = (f_noe == 1'b0) ? {2'b00, f_drv} : 'z;

  // ---- reference model ----
  logic [15:0] ref_mem [16];
  logic [15:0] last_rdata, f_last_rdata;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // Expected {NADV, NWE, NOE, AD driven, rsp_valid, cmd_ready} in cycle k
  // after an accept, straight from the phase-length arithmetic.
  function automatic logic [5:0] exp_ctl(input int k, input bit wr, input int a,
                                         input int h, input int d, input int b);
    bit in_adr, in_dat;
    in_adr = (k >= 1) && (k <= a);
    in_dat = (k > a + h) && (k <= a + h + d);
    return {!in_adr, !(wr && in_dat), !(!wr && in_dat),
            (k <= a + h) || (wr && in_dat), k == a + h + d + 1, k == a + h + d + b + 1};
  endfunction

  task automatic issue(input bit wr, input logic [17:0] addr, input logic [15:0] wd);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
  endtask

  // Called in the second half of the accept cycle with the command presented.
  task automatic run_txn(input bit wr, input logic [17:0] addr, input logic [15:0] wd,
                         input bit keep);
    logic [15:0] exp_rd;
    int n;
    n = A + H + D + B + 1;
    exp_rd = wr ? 16'h0 : ref_mem[addr[3:0]];
    if (wr) ref_mem[addr[3:0]] = wd;
    chk("accept_ready", 0, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk(wr ? "wr_ctl" : "rd_ctl", k, 32'({nadv, nwe, noe, u_dut.ad_oe, rsp_valid, cmd_ready}),
          32'(exp_ctl(k, wr, A, H, D, B)));
      chk("rdata", k, 32'(rsp_rdata), 32'((k > A + H + D) ? exp_rd : last_rdata));
      if (k <= A + H)               chk("ad_addr", k, 32'(ad_bus), 32'(addr));
      else if (wr && k <= A + H + D) chk("ad_wdata", k, 32'(ad_bus), 32'({2'b00, wd}));
    end
    last_rdata = exp_rd;
  endtask

  task automatic run_fast(input bit wr, input logic [17:0] addr, input logic [15:0] wd);
    logic [15:0] exp_rd;
    exp_rd = wr ? 16'h0 : f_drv;
    f_cmd_write = wr; f_cmd_addr = addr; f_cmd_wdata = wd; f_cmd_valid = 1'b1;
    chk("f_accept_ready", 0, 32'(f_cmd_ready), 32'd1);
    @(posedge clk); #1;
    f_cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("f_ctl", k, 32'({f_nadv, f_nwe, f_noe, u_fast.ad_oe, f_rsp_valid, f_cmd_ready}),
          32'(exp_ctl(k, wr, 1, 1, 1, 0)));
      chk("f_rdata", k, 32'(f_rsp_rdata), 32'((k == 4) ? exp_rd : f_last_rdata));
      if (k <= 2)            chk("f_ad_addr", k, 32'(f_ad), 32'(addr));
      else if (wr && k == 3) chk("f_ad_wdata", k, 32'(f_ad), 32'({2'b00, wd}));
    end
    f_last_rdata = exp_rd;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    f_cmd_valid = 1'b0; f_cmd_write = 1'b0; f_cmd_addr = '0; f_cmd_wdata = '0;
    f_drv = '0; last_rdata = '0; f_last_rdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 0, 32'({nadv, nwe, noe, u_dut.ad_oe, rsp_valid, cmd_ready}), 32'h38);
    chk("rst_rdata", 0, 32'(rsp_rdata), 32'h0);
    chk("f_rst_ctl", 0, 32'({f_nadv, f_nwe, f_noe, u_fast.ad_oe, f_rsp_valid, f_cmd_ready}), 32'h38);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 0, 32'(cmd_ready), 32'd1);
    chk("f_rel_ready", 0, 32'(f_cmd_ready), 32'd1);

    // directed write / write+read
    issue(1'b1, 18'h00001, 16'hA5A5); run_txn(1'b1, 18'h00001, 16'hA5A5, 1'b0);
    issue(1'b1, 18'h00002, 16'h1234); run_txn(1'b1, 18'h00002, 16'h1234, 1'b0);
    issue(1'b0, 18'h00002, 16'h0000); run_txn(1'b0, 18'h00002, 16'h0000, 1'b0);

    // back-to-back with cmd_valid held
    issue(1'b1, 18'h00003, 16'h1111); run_txn(1'b1, 18'h00003, 16'h1111, 1'b1);
    issue(1'b1, 18'h00004, 16'h2222); run_txn(1'b1, 18'h00004, 16'h2222, 1'b0);

    // reset in cycle 5 of a read
    issue(1'b0, 18'h00001, 16'h0000);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_noe_low", 5, 32'(noe), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ctl", 6, 32'({nadv, nwe, noe, u_dut.ad_oe, rsp_valid, cmd_ready}), 32'h39);
    chk("abort_rdata", 6, 32'(rsp_rdata), 32'h0);
    last_rdata = '0; f_last_rdata = '0;
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk);
      chk("no_rsp", c, 32'(rsp_valid), 32'd0);
    end

    // fill every location, then random mix checked against the model
    for (int i = 0; i < 16; i++) begin
      logic [17:0] a; logic [15:0] w;
      a = {14'($urandom), 4'(i)}; w = 16'($urandom);
      issue(1'b1, a, w); run_txn(1'b1, a, w, 1'b0);
    end
    repeat (40) begin
      logic [17:0] a; logic [15:0] w; bit wr;
      wr = 1'($urandom_range(0, 1)); a = 18'($urandom); w = 16'($urandom);
      issue(wr, a, w); run_txn(wr, a, w, 1'b0);
    end

    // minimum timing parameters, no turnaround
    f_drv = 16'($urandom);
    run_fast(1'b0, 18'h00005, 16'h0000);
    run_fast(1'b1, 18'h2ABCD, 16'($urandom));
    f_drv = 16'($urandom);
    run_fast(1'b0, 18'h00006, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
